// File: rtl/ff_ctrl_pkg.sv
// Shared types and default widths for the async-flop command sequencer.
package ff_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_SAMPLE = 2'b00,
    OP_PRESET = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_LOAD   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    PULSE,
    SETTLE,
    SAMPLE,
    RESP
  } state_e;

  localparam int DEF_PULSE_W  = 2;
  localparam int DEF_SETTLE_W = 1;
  localparam int DEF_CNT_W    = 4;

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter timing the PULSE and SETTLE phases; zero_o marks the last cycle of a phase.
module phase_counter
  import ff_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: count_d takes its hold value first so every path assigns it and no latch is inferred.
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/ff_ctrl_sequencer.sv
// Command sequencer for an async preset/reset flop: pulses preset_n/reset_n or drives D,
// waits a settling interval, samples Q and reports it with a compare against the expected value.
module ff_ctrl_sequencer
  import ff_ctrl_pkg::*;
#(
  parameter int PULSE_W  = DEF_PULSE_W,
  parameter int SETTLE_W = DEF_SETTLE_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic       req_d,
  output logic       done_valid,
  input  logic       done_ready,
  output logic       done_q,
  output logic       done_ok,
  output logic       busy,
  output logic       tgt_preset_n,
  output logic       tgt_reset_n,
  output logic       tgt_d,
  input  logic       tgt_q
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  if ((PULSE_W < 1) || (PULSE_W > CNT_MAX) || (SETTLE_W < 0) || (SETTLE_W > CNT_MAX)) begin : g_bad_params
    $fatal(1, "ff_ctrl_sequencer: PULSE_W/SETTLE_W out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = (SETTLE_W > 0) ? CNT_W'(SETTLE_W - 1) : '0;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic             exp_q, exp_d;
  logic             preset_n_q, preset_n_d;
  logic             clear_n_q, clear_n_d;
  logic             tgt_d_q, tgt_d_d;
  logic             sampled_q, sampled_d;
  logic             match_q, match_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             accept;

  phase_counter #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  assign req_ready = (state_q == IDLE) && reset_n;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    exp_d     = exp_q;
    tgt_d_d   = tgt_d_q;
    sampled_d = sampled_q;
    match_d   = match_q;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_dec   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = op_e'(req_op);
          unique case (op_e'(req_op))
            OP_PRESET: exp_d = 1'b1;
            OP_CLEAR:  exp_d = 1'b0;
            OP_LOAD:   exp_d = req_d;
            default:   exp_d = 1'b0;
          endcase
          if (op_e'(req_op) == OP_LOAD) begin
            tgt_d_d = req_d;
          end
          if (op_e'(req_op) == OP_SAMPLE) begin
            state_d = SAMPLE;
          end else begin
            state_d  = PULSE;
            cnt_load = 1'b1;
            cnt_val  = PULSE_LD;
          end
        end
      end
      PULSE: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (SETTLE_W == 0) begin
          state_d = SAMPLE;
        end else begin
          state_d  = SETTLE;
          cnt_load = 1'b1;
          cnt_val  = SETTLE_LD;
        end
      end
      SETTLE: begin
        if (cnt_zero) begin
          state_d = SAMPLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      SAMPLE: begin
        sampled_d = tgt_q;
        match_d   = (op_q == OP_SAMPLE) ? 1'b1 : (tgt_q == exp_q);
        state_d   = RESP;
      end
      RESP: begin
        if (done_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Controls are decoded from the next state so the registered pins line up with PULSE exactly.
    preset_n_d = !((state_d == PULSE) && (op_d == OP_PRESET));
    clear_n_d  = !((state_d == PULSE) && (op_d == OP_CLEAR));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      op_q       <= OP_SAMPLE;
      exp_q      <= 1'b0;
      preset_n_q <= 1'b1;
      clear_n_q  <= 1'b1;
      tgt_d_q    <= 1'b0;
      sampled_q  <= 1'b0;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      exp_q      <= exp_d;
      preset_n_q <= preset_n_d;
      clear_n_q  <= clear_n_d;
      tgt_d_q    <= tgt_d_d;
      sampled_q  <= sampled_d;
      match_q    <= match_d;
    end
  end

  assign tgt_preset_n = preset_n_q;
  assign tgt_reset_n  = clear_n_q;
  assign tgt_d        = tgt_d_q;
  assign done_valid   = (state_q == RESP);
  assign done_q       = sampled_q;
  assign done_ok      = match_q;
  assign busy         = (state_q != IDLE);

endmodule
